// File: rtl/spec_acc_sequencer.sv
// Spectral accumulation sequencer: counts range bins/pulses during FFT frames, then runs the POST and PEAK sweeps.
// Optional abort input is enabled by defining SPEC_ACC_SEQ_ABORT_EN.
module spec_acc_sequencer #(
    parameter int N_FFT   = 512,
    parameter int IDX_W   = 10,
    parameter int RB_W    = 5,
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RB_W-1:0]    num_rb,
    input  logic [PULSE_W-1:0] num_pulse,
    input  logic               fft_valid,
`ifdef SPEC_ACC_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [RB_W-1:0]    range_bin_cnt,
    output logic [IDX_W-1:0]   range_in_cnt,
    output logic               post_process_ctrl,
    output logic               peak_detection_ctrl,
    output logic               busy,
    output logic               run_done,
    output logic               err_overrun
);
    typedef enum logic [2:0] {IDLE, ACCUM, POST, PEAK, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);

    state_t             r_state, w_state_n;
    logic [RB_W-1:0]    r_rb, w_rb_n, r_nrb, w_nrb_n;
    logic [IDX_W-1:0]   r_idx, w_idx_n;
    logic [PULSE_W-1:0] r_pulse, w_pulse_n, r_npl, w_npl_n, w_pinc;
    logic               r_fv, r_err, w_err_n;
    logic               r_post, r_peak, r_busy, r_done;
    logic               w_fend, w_last_rb, w_last_idx;

    assign w_fend     = r_fv & ~fft_valid;
    assign w_last_rb  = (r_rb == r_nrb);
    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_pinc     = r_pulse + PULSE_W'(1);

    always_comb begin
        w_state_n = r_state;
        w_rb_n    = r_rb;
        w_idx_n   = r_idx;
        w_pulse_n = r_pulse;
        w_nrb_n   = r_nrb;
        w_npl_n   = r_npl;
        w_err_n   = r_err;
        case (r_state)
            IDLE: if (start) begin
                w_nrb_n   = (num_rb == '0) ? RB_W'(1) : num_rb;
                w_npl_n   = (num_pulse == '0) ? PULSE_W'(1) : num_pulse;
                w_err_n   = 1'b0;
                w_rb_n    = RB_W'(1);
                w_idx_n   = '0;
                w_pulse_n = '0;
                w_state_n = ACCUM;
            end
            ACCUM: if (w_fend) begin
                if (w_last_rb) begin
                    w_pulse_n = w_pinc;
                    w_rb_n    = RB_W'(1);
                    // Last pulse wins over the bin wrap: jump straight into the sweeps
                    if (w_pinc == r_npl) begin
                        w_idx_n = '0;
                        if (r_nrb >= RB_W'(2)) begin
                            w_rb_n    = RB_W'(2);
                            w_state_n = POST;
                        end else begin
                            w_state_n = DONE;
                        end
                    end
                end else begin
                    w_rb_n = r_rb + RB_W'(1);
                end
            end
            POST, PEAK: begin
                w_idx_n = r_idx + IDX_W'(1);
                if (w_last_idx) begin
                    w_idx_n = '0;
                    if (w_last_rb) begin
                        w_rb_n    = (r_state == POST) ? RB_W'(2) : RB_W'(1);
                        w_state_n = (r_state == POST) ? PEAK : DONE;
                    end else begin
                        w_rb_n = r_rb + RB_W'(1);
                    end
                end
            end
            DONE: begin
                w_rb_n    = RB_W'(1);
                w_idx_n   = '0;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
        if (fft_valid && (r_state == POST || r_state == PEAK || r_state == DONE))
            w_err_n = 1'b1;
`ifdef SPEC_ACC_SEQ_ABORT_EN
        // Abort drops back to idle silently; the overrun flag is kept for inspection
        if (abort && r_state != IDLE) begin
            w_state_n = IDLE;
            w_rb_n    = RB_W'(1);
            w_idx_n   = '0;
            w_pulse_n = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rb    <= RB_W'(1);
            r_idx   <= '0;
            r_pulse <= '0;
            r_nrb   <= RB_W'(1);
            r_npl   <= PULSE_W'(1);
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
            r_post  <= 1'b0;
            r_peak  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rb    <= w_rb_n;
            r_idx   <= w_idx_n;
            r_pulse <= w_pulse_n;
            r_nrb   <= w_nrb_n;
            r_npl   <= w_npl_n;
            r_fv    <= fft_valid;
            r_err   <= w_err_n;
            r_post  <= (w_state_n == POST);
            r_peak  <= (w_state_n == PEAK);
            r_busy  <= (w_state_n != IDLE);
            r_done  <= (w_state_n == DONE);
        end
    end

    assign range_bin_cnt       = r_rb;
    assign range_in_cnt        = r_idx;
    assign post_process_ctrl   = r_post;
    assign peak_detection_ctrl = r_peak;
    assign busy                = r_busy;
    assign run_done            = r_done;
    assign err_overrun         = r_err;
endmodule

// File: tb/tb_spec_acc_sequencer.sv
// Directed bench for spec_acc_sequencer: frame counting, sweep lengths, overrun, ignored start, mid-run reset.
module tb_spec_acc_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  num_rb = '0;
    logic [15:0] num_pulse = '0;
    logic        fft_valid = 1'b0;
    logic [4:0]  range_bin_cnt;
    logic [9:0]  range_in_cnt;
    logic        post_process_ctrl, peak_detection_ctrl, busy, run_done, err_overrun;

    int total = 0;
    int bad   = 0;

    spec_acc_sequencer #(.N_FFT(512), .IDX_W(10), .RB_W(5), .PULSE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rb(num_rb), .num_pulse(num_pulse),
        .fft_valid(fft_valid), .range_bin_cnt(range_bin_cnt), .range_in_cnt(range_in_cnt),
        .post_process_ctrl(post_process_ctrl), .peak_detection_ctrl(peak_detection_ctrl),
        .busy(busy), .run_done(run_done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [4:0] rb, input logic [15:0] np);
        start = 1'b1; num_rb = rb; num_pulse = np;
        tick();
        start = 1'b0;
    endtask

    // Returns right after the edge that sees the falling edge of fft_valid.
    task automatic send_frame(input int len);
        fft_valid = 1'b1;
        repeat (len) tick();
        fft_valid = 1'b0;
        tick();
    endtask

    // Samples every cycle until busy drops; optionally raises fft_valid for inj_len cycles at inj_at.
    task automatic measure(input int inj_at, input int inj_len,
                           output int np, output int nk, output int nd, output int nov,
                           output int pk_rb, output int pk_idx, output logic last_done,
                           output logic timeout);
        int i;
        np = 0; nk = 0; nd = 0; nov = 0; pk_rb = -1; pk_idx = -1; last_done = 1'b0;
        i = 0;
        while (busy && i < 10000) begin
            if (post_process_ctrl) np++;
            if (peak_detection_ctrl) begin
                if (nk == 0) begin pk_rb = int'(range_bin_cnt); pk_idx = int'(range_in_cnt); end
                nk++;
            end
            if (run_done) nd++;
            if (post_process_ctrl && peak_detection_ctrl) nov++;
            last_done = run_done;
            if (i == inj_at) fft_valid = 1'b1;
            if (i == inj_at + inj_len) fft_valid = 1'b0;
            tick();
            i++;
        end
        fft_valid = 1'b0;
        timeout = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if ({range_bin_cnt, range_in_cnt} !== {5'd1, 10'd0}) begin bad++;
            $display("FAIL reset_cnt: rb=%0d idx=%0d want 1/0", range_bin_cnt, range_in_cnt); end
        total++; if ({post_process_ctrl, peak_detection_ctrl, busy, run_done, err_overrun} !== 5'b0) begin bad++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {post_process_ctrl, peak_detection_ctrl, busy, run_done, err_overrun}); end
    endtask

    task automatic test_basic_run();
        int exp_rb [8] = '{2, 3, 4, 1, 2, 3, 4, 2};
        int np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd4, 16'd2);
        total++; if (busy !== 1'b1 || range_bin_cnt !== 5'd1) begin bad++;
            $display("FAIL basic_start: busy=%b rb=%0d want 1/1", busy, range_bin_cnt); end
        for (int f = 0; f < 8; f++) begin
            send_frame(512);
            total++; if (int'(range_bin_cnt) != exp_rb[f]) begin bad++;
                $display("FAIL basic_rb_f%0d: got %0d want %0d", f, range_bin_cnt, exp_rb[f]); end
        end
        total++; if (post_process_ctrl !== 1'b1 || range_in_cnt !== 10'd0) begin bad++;
            $display("FAIL basic_post_entry: post=%b idx=%0d want 1/0", post_process_ctrl, range_in_cnt); end
        measure(-10, 0, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout: busy stuck"); end
        total++; if (np != 1536) begin bad++; $display("FAIL basic_post_len: got %0d want 1536", np); end
        total++; if (nk != 1536) begin bad++; $display("FAIL basic_peak_len: got %0d want 1536", nk); end
        total++; if (prb != 2 || pidx != 0) begin bad++;
            $display("FAIL basic_peak_entry: rb=%0d idx=%0d want 2/0", prb, pidx); end
        total++; if (nd != 1 || ld !== 1'b1) begin bad++;
            $display("FAIL basic_done: pulses=%0d last=%b want 1/1", nd, ld); end
        total++; if (nov != 0) begin bad++; $display("FAIL basic_overlap: got %0d want 0", nov); end
        total++; if (range_bin_cnt !== 5'd1 || range_in_cnt !== 10'd0 || run_done !== 1'b0) begin bad++;
            $display("FAIL basic_idle: rb=%0d idx=%0d done=%b want 1/0/0", range_bin_cnt, range_in_cnt, run_done); end
    endtask

    task automatic test_single_rb();
        int np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd1, 16'd3);
        for (int f = 0; f < 2; f++) begin
            send_frame(8);
            total++; if (range_bin_cnt !== 5'd1 || run_done !== 1'b0 || busy !== 1'b1) begin bad++;
                $display("FAIL rb1_f%0d: rb=%0d done=%b busy=%b want 1/0/1", f, range_bin_cnt, run_done, busy); end
        end
        send_frame(8);
        total++; if (run_done !== 1'b1) begin bad++; $display("FAIL rb1_done_now: got %b want 1", run_done); end
        measure(-10, 0, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (np != 0 || nk != 0 || nd != 1 || to) begin bad++;
            $display("FAIL rb1_tail: post=%0d peak=%0d done=%0d to=%b want 0/0/1/0", np, nk, nd, to); end
    endtask

    task automatic test_zero_pulse();
        int np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd2, 16'd0);
        send_frame(8);
        total++; if (range_bin_cnt !== 5'd2 || post_process_ctrl !== 1'b0) begin bad++;
            $display("FAIL np0_f0: rb=%0d post=%b want 2/0", range_bin_cnt, post_process_ctrl); end
        send_frame(8);
        total++; if (post_process_ctrl !== 1'b1 || range_bin_cnt !== 5'd2) begin bad++;
            $display("FAIL np0_post: post=%b rb=%0d want 1/2", post_process_ctrl, range_bin_cnt); end
        measure(-10, 0, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (np != 512 || nk != 512 || nd != 1 || to) begin bad++;
            $display("FAIL np0_tail: post=%0d peak=%0d done=%0d want 512/512/1", np, nk, nd); end
    endtask

    task automatic test_overrun();
        int np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd2, 16'd1);
        send_frame(8);
        send_frame(8);
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %b want 0", err_overrun); end
        measure(20, 10, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (np != 512 || nk != 512 || nd != 1) begin bad++;
            $display("FAIL ovr_len: post=%0d peak=%0d done=%0d want 512/512/1", np, nk, nd); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", err_overrun); end
    endtask

    task automatic test_ignore_start();
        int np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd4, 16'd1);
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err_overrun); end
        send_frame(8);
        do_start(5'd7, 16'd5);
        total++; if (range_bin_cnt !== 5'd2 || busy !== 1'b1) begin bad++;
            $display("FAIL ign_start: rb=%0d busy=%b want 2/1", range_bin_cnt, busy); end
        send_frame(8);
        send_frame(8);
        total++; if (range_bin_cnt !== 5'd4) begin bad++; $display("FAIL ign_rb4: got %0d want 4", range_bin_cnt); end
        send_frame(8);
        total++; if (post_process_ctrl !== 1'b1 || range_bin_cnt !== 5'd2) begin bad++;
            $display("FAIL ign_wrap: post=%b rb=%0d want 1/2", post_process_ctrl, range_bin_cnt); end
        measure(-10, 0, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (np != 1536 || nk != 1536 || nd != 1) begin bad++;
            $display("FAIL ign_tail: post=%0d peak=%0d done=%0d want 1536/1536/1", np, nk, nd); end
    endtask

    task automatic test_rst_mid_run();
        int i, dn, np, nk, nd, nov, prb, pidx; logic ld, to;
        do_start(5'd2, 16'd1);
        send_frame(8);
        send_frame(8);
        i = 0;
        while (!(peak_detection_ctrl && range_in_cnt == 10'd100) && i < 3000) begin tick(); i++; end
        total++; if (i >= 3000) begin bad++; $display("FAIL rst_reach_peak: timed out"); end
        rst = 1'b1;
        #2;
        total++; if ({range_bin_cnt, range_in_cnt} !== {5'd1, 10'd0}) begin bad++;
            $display("FAIL rst_async_cnt: rb=%0d idx=%0d want 1/0", range_bin_cnt, range_in_cnt); end
        total++; if ({post_process_ctrl, peak_detection_ctrl, busy, run_done, err_overrun} !== 5'b0) begin bad++;
            $display("FAIL rst_async_ctl: got %b want 00000",
                     {post_process_ctrl, peak_detection_ctrl, busy, run_done, err_overrun}); end
        dn = 0;
        repeat (2) begin tick(); if (run_done) dn++; end
        rst = 1'b0;
        repeat (5) begin tick(); if (run_done || busy) dn++; end
        total++; if (dn != 0) begin bad++; $display("FAIL rst_no_done: saw %0d active cycles want 0", dn); end
        do_start(5'd3, 16'd1);
        for (int f = 0; f < 3; f++) send_frame(8);
        measure(-10, 0, np, nk, nd, nov, prb, pidx, ld, to);
        total++; if (np != 1024 || nk != 1024 || nd != 1) begin bad++;
            $display("FAIL rst_rerun: post=%0d peak=%0d done=%0d want 1024/1024/1", np, nk, nd); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_single_rb();
        test_zero_pulse();
        test_overrun();
        test_ignore_start();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spec_acc_sequencer.md
Name: spec_acc_sequencer

Overview:
- Top-level sequencer for the spectral accumulation datapath.
- Tracks range bin and pulse counts while FFT frames arrive and drives the DPRAM address generator's phase controls (range bin counter, readout index, post-process and peak-detection enables).
- Then runs the background-subtraction sweep and the peak-detection readout sweep over every signal range bin, and flags completion.

Parameters:
- N_FFT, 512: FFT points per range bin. This is the sweep length in the POST and PEAK phases (at most 2^IDX_W).
- IDX_W, 10: width of the spectral index / readout counter.
- RB_W, 5: width of the range bin counter.
- PULSE_W, 16: width of the pulse (shot) counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to begin an accumulation run
- num_rb  in  RB_W  range bins per pulse, including bin 1 (background); latched at start
- num_pulse  in  PULSE_W  pulses to accumulate; latched at start
- fft_valid  in  1  high while the FFT outputs one range bin's spectrum
- range_bin_cnt  out  RB_W  current range bin, 1-based
- range_in_cnt  out  IDX_W  spectral index during POST/PEAK sweeps
- post_process_ctrl  out  1  high throughout the POST phase
- peak_detection_ctrl  out  1  high throughout the PEAK phase
- busy  out  1  high in any state except IDLE
- run_done  out  1  single-cycle pulse when the run completes
- err_overrun  out  1  sticky flag: fft_valid was seen outside ACCUM while busy

Behaviour:
- Reset values:
  - range_bin_cnt = 1
  - range_in_cnt = 0
  - all control and status outputs = 0
  - FSM in IDLE
  - internal pulse counter = 0
- FSM states: IDLE, ACCUM, POST, PEAK, DONE. All outputs are registered.
- IDLE:
  - start=1 latches num_rb and num_pulse, clears err_overrun, sets range_bin_cnt=1 and pulse counter=0, and moves to ACCUM.
  - A latched num_pulse of 0 is treated as 1.
  - A latched num_rb of 0 is treated as 1.
- ACCUM:
  - A falling edge of fft_valid (registered fft_valid=1, current fft_valid=0) marks the end of one range bin frame.
  - At a frame end with range_bin_cnt < num_rb: increment range_bin_cnt.
  - At a frame end with range_bin_cnt = num_rb: set range_bin_cnt=1 and increment the pulse counter.
  - When the incremented pulse count equals num_pulse:
    - if num_rb >= 2: go to POST with range_bin_cnt=2 and range_in_cnt=0;
    - otherwise go straight to DONE.
- POST:
  - post_process_ctrl=1.
  - range_in_cnt increments every cycle from 0 to N_FFT-1.
  - At N_FFT-1: wrap to 0 and increment range_bin_cnt.
  - After the cycle with range_bin_cnt=num_rb and range_in_cnt=N_FFT-1: go to PEAK with range_bin_cnt=2 and range_in_cnt=0.
  - Phase length: (num_rb-1)*N_FFT cycles.
- PEAK:
  - peak_detection_ctrl=1.
  - Sweep is identical to POST.
  - On completion go to DONE.
  - post_process_ctrl and peak_detection_ctrl are never high together.
- DONE:
  - run_done=1 for exactly one cycle.
  - range_bin_cnt=1, range_in_cnt=0.
  - Next state is IDLE.
- start while busy: ignored. No relatch, no restart.
- fft_valid high in POST, PEAK or DONE: sets err_overrun. It stays set until the next accepted start or rst. The sweeps are not disturbed.
- Simultaneous frame end and last pulse: the transition to POST takes priority over the range_bin_cnt wrap.
- rst mid-run: all outputs return to reset values immediately and asynchronously. No run_done is emitted.
- busy: goes high the cycle after start is accepted and falls in the cycle after run_done.

Optional Feature:
- Macro: SPEC_ACC_SEQ_ABORT_EN.
- When defined:
  - adds input port abort (1 bit);
  - abort=1 in any busy state forces IDLE on the next edge;
  - range_bin_cnt and range_in_cnt return to reset values;
  - run_done is not pulsed;
  - err_overrun is retained.
- When undefined: no abort port; a run can only be terminated by rst.

Test Plan:
- num_rb=4, num_pulse=2, 8 fft_valid frames of 512 cycles each.
  - range_bin_cnt steps 1,2,3,4,1,2,3,4.
  - POST then lasts 1536 cycles, PEAK lasts 1536 cycles.
  - run_done pulses once; busy then falls.
- num_rb=1, num_pulse=3, 3 frames.
  - post_process_ctrl and peak_detection_ctrl are never asserted.
  - run_done pulses one cycle after the 3rd frame end.
- num_pulse=0, num_rb=2: one pulse of 2 frames completes ACCUM, behaving the same as num_pulse=1.
- fft_valid asserted for 10 cycles during POST: err_overrun=1, sweep length unchanged. A new start clears err_overrun.
- start pulsed mid-ACCUM with num_rb=7: ignored; the original num_rb=4 wrap behaviour persists.
- rst asserted in PEAK at range_in_cnt=100: all outputs return to reset values immediately; no run_done pulse; a subsequent start runs a full sequence.
